execute_stage: RTL and testbench

EXECUTE_STAGE -- requirements
Module: execute_stage

---
 rtl/execute_stage.sv | 150 +++++++++++++++
 tb/tb_execute_stage.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/execute_stage.sv
// execute_stage: forwarding muxes, 19-bit ALU and E->M pipeline registers.
// Define EXECUTE_DIV_EN to add the multi-cycle restoring divider that stalls upstream.
module execute_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic        RegWriteE,
  input  logic        MemWriteE,
  input  logic        ResultSrcE,
  input  logic        Cant_ByteE,
  input  logic        ALUSrcE,
  input  logic        ValidE,
  input  logic [3:0]  ALUControlE,
  input  logic [18:0] RD1E,
  input  logic [18:0] RD2E,
  input  logic [18:0] ImmE,
  input  logic [4:0]  RdE,
  input  logic [1:0]  ForwardAE,
  input  logic [1:0]  ForwardBE,
  input  logic [18:0] ResultW,
  output logic        RegWriteM,
  output logic        MemWriteM,
  output logic        ResultSrcM,
  output logic        Cant_ByteM,
  output logic [4:0]  RDM,
  output logic [18:0] ALUResultM,
  output logic [18:0] WriteDataM,
  output logic        StallE
);
  logic [18:0] src_a, fwd_b, src_b, alu_y;
  assign src_a = ForwardAE == 2'b01 ? ResultW : ForwardAE == 2'b10 ? ALUResultM : RD1E;
  assign fwd_b = ForwardBE == 2'b01 ? ResultW : ForwardBE == 2'b10 ? ALUResultM : RD2E;
  assign src_b = ALUSrcE ? ImmE : fwd_b;
  always_comb begin
    alu_y = '0;
    case (ALUControlE)
      4'b0000: alu_y = src_a + src_b;
      4'b0001: alu_y = src_a - src_b;
      4'b0010: alu_y = src_a & src_b;
      4'b0011: alu_y = src_a | src_b;
      4'b0100: alu_y = src_a ^ src_b;
      4'b0101: alu_y = src_b[4:0] >= 5'd19 ? '0 : src_a << src_b[4:0];
      4'b0110: alu_y = src_b[4:0] >= 5'd19 ? '0 : src_a >> src_b[4:0];
      4'b0111: alu_y = {18'd0, $signed(src_a) < $signed(src_b)};
      4'b1000: alu_y = src_a * src_b;
      default: alu_y = '0;
    endcase
  end
`ifdef EXECUTE_DIV_EN
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t state, state_n;
  logic [4:0]  cnt, rd_h;
  logic [18:0] quo, dvs, rem, diff, wd_h;
  logic [19:0] r_sh;
  logic        is_div, ge, op_rem, rw_h, mw_h, rs_h, cb_h;
  assign is_div = ALUControlE == 4'b1001 || ALUControlE == 4'b1010;
  // Restoring step: dividend bits shift out of quo into the partial remainder.
  assign r_sh = {rem, quo[18]};
  assign ge   = r_sh >= {1'b0, dvs};
  assign diff = r_sh[18:0] - dvs;
  always_comb begin
    state_n = state;
    StallE  = 1'b0;
    case (state)
      IDLE: if (ValidE && is_div) begin
        state_n = BUSY;
        StallE  = 1'b1;
      end
      BUSY: begin
        StallE  = 1'b1;
        state_n = cnt == 5'd18 ? DONE : BUSY;
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      cnt    <= '0;
      quo    <= '0;
      dvs    <= '0;
      rem    <= '0;
      wd_h   <= '0;
      rd_h   <= '0;
      op_rem <= 1'b0;
      rw_h   <= 1'b0;
      mw_h   <= 1'b0;
      rs_h   <= 1'b0;
      cb_h   <= 1'b0;
    end else begin
      state <= state_n;
      if (state == IDLE && state_n == BUSY) begin
        quo    <= src_a;
        dvs    <= src_b;
        rem    <= '0;
        cnt    <= '0;
        wd_h   <= fwd_b;
        rd_h   <= RdE;
        op_rem <= ALUControlE[1];
        rw_h   <= RegWriteE;
        mw_h   <= MemWriteE;
        rs_h   <= ResultSrcE;
        cb_h   <= Cant_ByteE;
      end else if (state == BUSY) begin
        cnt <= cnt + 5'd1;
        quo <= {quo[17:0], ge};
        rem <= ge ? diff : r_sh[18:0];
      end
    end
  end
`else
  assign StallE = 1'b0;
`endif
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      RegWriteM  <= 1'b0;
      MemWriteM  <= 1'b0;
      ResultSrcM <= 1'b0;
      Cant_ByteM <= 1'b0;
      RDM        <= '0;
      ALUResultM <= '0;
      WriteDataM <= '0;
    end
`ifdef EXECUTE_DIV_EN
    else if (state == DONE) begin
      RegWriteM  <= rw_h;
      MemWriteM  <= mw_h;
      ResultSrcM <= rs_h;
      Cant_ByteM <= cb_h;
      RDM        <= rd_h;
      ALUResultM <= op_rem ? rem : quo;
      WriteDataM <= wd_h;
    end
`endif
    else if (ValidE && !StallE) begin
      RegWriteM  <= RegWriteE;
      MemWriteM  <= MemWriteE;
      ResultSrcM <= ResultSrcE;
      Cant_ByteM <= Cant_ByteE;
      RDM        <= RdE;
      ALUResultM <= alu_y;
      WriteDataM <= fwd_b;
    end else begin
      RegWriteM  <= 1'b0;
      MemWriteM  <= 1'b0;
      ResultSrcM <= 1'b0;
      Cant_ByteM <= 1'b0;
      RDM        <= '0;
    end
  end
endmodule

// File: tb/tb_execute_stage.sv
// tb_execute_stage: directed and random checks of execute_stage against an arithmetic model.
// Divider checks are compiled when EXECUTE_DIV_EN is defined.
module tb_execute_stage;
  logic        clk = 1'b0;
  logic        reset;
  logic        RegWriteE, MemWriteE, ResultSrcE, Cant_ByteE, ALUSrcE, ValidE;
  logic [3:0]  ALUControlE;
  logic [18:0] RD1E, RD2E, ImmE, ResultW;
  logic [4:0]  RdE;
  logic [1:0]  ForwardAE, ForwardBE;
  logic        RegWriteM, MemWriteM, ResultSrcM, Cant_ByteM, StallE;
  logic [4:0]  RDM;
  logic [18:0] ALUResultM, WriteDataM;
  int checks = 0;
  int failures = 0;
  logic [18:0] m_alu;
  bit          known;

  execute_stage dut (
    .clk(clk), .reset(reset),
    .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .ResultSrcE(ResultSrcE),
    .Cant_ByteE(Cant_ByteE), .ALUSrcE(ALUSrcE), .ValidE(ValidE),
    .ALUControlE(ALUControlE), .RD1E(RD1E), .RD2E(RD2E), .ImmE(ImmE), .RdE(RdE),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .ResultW(ResultW),
    .RegWriteM(RegWriteM), .MemWriteM(MemWriteM), .ResultSrcM(ResultSrcM),
    .Cant_ByteM(Cant_ByteM), .RDM(RDM), .ALUResultM(ALUResultM),
    .WriteDataM(WriteDataM), .StallE(StallE)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
      $error("%s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int sgn(input logic [18:0] v);
    return v[18] ? int'(v) - (1 << 19) : int'(v);
  endfunction

  function automatic logic [18:0] ref_alu(input logic [3:0] op, input logic [18:0] a, input logic [18:0] b);
    longint ua = longint'(a);
    longint ub = longint'(b);
    longint amt = longint'(b[4:0]);
    case (op)
      4'd0: return 19'((ua + ub) % (1 << 19));
      4'd1: return 19'((ua - ub + (1 << 19)) % (1 << 19));
      4'd2: return a & b;
      4'd3: return a | b;
      4'd4: return a ^ b;
      4'd5: return amt >= 19 ? 19'd0 : 19'((ua * (longint'(1) << amt)) % (1 << 19));
      4'd6: return amt >= 19 ? 19'd0 : 19'(ua / (longint'(1) << amt));
      4'd7: return sgn(a) < sgn(b) ? 19'd1 : 19'd0;
      4'd8: return 19'((ua * ub) % (1 << 19));
`ifdef EXECUTE_DIV_EN
      4'd9:  return ub == 0 ? 19'h7FFFF : 19'(ua / ub);
      4'd10: return ub == 0 ? a : 19'(ua % ub);
`endif
      default: return 19'd0;
    endcase
  endfunction

  function automatic logic [18:0] fwd(input logic [1:0] sel, input logic [18:0] rdx);
    return sel == 2'b01 ? ResultW : sel == 2'b10 ? m_alu : rdx;
  endfunction

  task automatic setin(input logic v, input logic [3:0] op, input logic [18:0] a, input logic [18:0] b,
                       input logic [18:0] imm, input logic asrc, input logic [1:0] fa, input logic [1:0] fb,
                       input logic rw, input logic mw, input logic rs, input logic cb, input logic [4:0] rd);
    ValidE = v; ALUControlE = op; RD1E = a; RD2E = b; ImmE = imm; ALUSrcE = asrc;
    ForwardAE = fa; ForwardBE = fb; RegWriteE = rw; MemWriteE = mw; ResultSrcE = rs;
    Cant_ByteE = cb; RdE = rd;
  endtask

  task automatic run_op(input string tag, input logic v, input logic [3:0] op, input logic [18:0] a,
                        input logic [18:0] b, input logic [18:0] imm, input logic asrc,
                        input logic [1:0] fa, input logic [1:0] fb, input logic rw, input logic mw,
                        input logic rs, input logic cb, input logic [4:0] rd);
    logic [18:0] fb_v, e;
    @(negedge clk);
    setin(v, op, a, b, imm, asrc, fa, fb, rw, mw, rs, cb, rd);
    fb_v = fwd(fb, b);
    e = ref_alu(op, fwd(fa, a), asrc ? imm : fb_v);
    #1 chk({tag, " stall"}, 32'(StallE), 0);
    @(posedge clk); #1;
    chk({tag, " regwrite"}, 32'(RegWriteM), 32'(v & rw));
    chk({tag, " memwrite"}, 32'(MemWriteM), 32'(v & mw));
    chk({tag, " resultsrc"}, 32'(ResultSrcM), 32'(v & rs));
    chk({tag, " cantbyte"}, 32'(Cant_ByteM), 32'(v & cb));
    chk({tag, " rdm"}, 32'(RDM), v ? 32'(rd) : 0);
    if (v) begin
      chk({tag, " alu"}, 32'(ALUResultM), 32'(e));
      chk({tag, " wdata"}, 32'(WriteDataM), 32'(fb_v));
      m_alu = e;
      known = 1;
    end else known = 0;
  endtask

`ifdef EXECUTE_DIV_EN
  task automatic do_div(input string tag, input logic [3:0] op, input logic [18:0] a,
                        input logic [18:0] b, input logic [18:0] exp);
    @(negedge clk);
    setin(1, op, a, b, 19'($urandom), 0, 2'b00, 2'b00, 1, 0, 1, 0, 5'd9);
    #1 chk({tag, " stall issue"}, 32'(StallE), 1);
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      chk({tag, " bubble regwrite"}, 32'(RegWriteM), 0);
      chk({tag, " bubble resultsrc"}, 32'(ResultSrcM), 0);
      @(negedge clk);
      RD1E = 19'($urandom); RD2E = 19'($urandom); ResultW = 19'($urandom);
      ForwardAE = 2'($urandom); ForwardBE = 2'($urandom);
      ValidE = 1'($urandom); ALUControlE = 4'($urandom);
      #1 chk({tag, " stall"}, 32'(StallE), i < 19 ? 1 : 0);
    end
    ValidE = 0;
    @(posedge clk); #1;
    chk({tag, " result"}, 32'(ALUResultM), 32'(exp));
    chk({tag, " regwrite"}, 32'(RegWriteM), 1);
    chk({tag, " resultsrc"}, 32'(ResultSrcM), 1);
    chk({tag, " rdm"}, 32'(RDM), 9);
    m_alu = exp;
    known = 1;
    @(posedge clk); #1;
    chk({tag, " no reissue"}, 32'(RegWriteM), 0);
    known = 0;
  endtask
`endif

  initial begin
    reset = 1'b0;
    ResultW = '0;
    setin(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    chk("reset alu", 32'(ALUResultM), 0);
    chk("reset wdata", 32'(WriteDataM), 0);
    chk("reset regwrite", 32'(RegWriteM), 0);
    chk("reset rdm", 32'(RDM), 0);
    chk("reset stall", 32'(StallE), 0);
    m_alu = '0;
    known = 1;
    repeat (2) @(negedge clk);
    reset = 1'b1;

    run_op("add", 1, 4'b0000, 19'h00010, 19'h0, 19'h00005, 1, 2'b00, 2'b00, 1, 0, 0, 0, 5'd3);
    chk("add const", 32'(ALUResultM), 32'h15);
    run_op("fwd sub", 1, 4'b0001, 19'h0, 19'h00002, 19'h0, 0, 2'b10, 2'b00, 1, 0, 0, 0, 5'd4);
    chk("fwd sub const", 32'(ALUResultM), 32'h13);
    run_op("store", 1, 4'b0000, 19'h0, 19'h0EEFF, 19'h6, 1, 2'b00, 2'b00, 0, 1, 0, 1, 5'd0);
    chk("store wdata const", 32'(WriteDataM), 32'h0EEFF);
    chk("store alu const", 32'(ALUResultM), 32'h6);
    run_op("bubble", 0, 4'b0000, 19'h1, 19'h2, 19'h3, 0, 2'b00, 2'b00, 1, 1, 1, 1, 5'd7);
    run_op("sll 19", 1, 4'b0101, 19'h00001, 19'h0, 19'd19, 1, 2'b00, 2'b00, 1, 0, 0, 0, 5'd1);
    chk("sll 19 const", 32'(ALUResultM), 0);
    run_op("sll 18", 1, 4'b0101, 19'h00001, 19'h0, 19'd18, 1, 2'b00, 2'b00, 1, 0, 0, 0, 5'd1);
    chk("sll 18 const", 32'(ALUResultM), 32'h40000);
    run_op("slt neg", 1, 4'b0111, 19'h7FFFF, 19'h00001, 19'h0, 0, 2'b00, 2'b00, 1, 0, 0, 0, 5'd2);
    chk("slt neg const", 32'(ALUResultM), 1);
    run_op("op 1011", 1, 4'b1011, 19'h12345, 19'h00001, 19'h0, 0, 2'b00, 2'b00, 1, 0, 0, 0, 5'd2);
    run_op("fwd w", 1, 4'b0100, 19'h0, 19'h0, 19'h0, 0, 2'b01, 2'b01, 1, 0, 0, 0, 5'd2);

    for (int i = 0; i < 60; i++) begin
      logic [3:0] op;
      logic [1:0] fa, fb;
      op = 4'($urandom_range(0, 15));
`ifdef EXECUTE_DIV_EN
      if (op == 4'd9 || op == 4'd10) op = 4'd8;
`endif
      fa = 2'($urandom);
      fb = 2'($urandom);
      if (!known && fa == 2'b10) fa = 2'b00;
      if (!known && fb == 2'b10) fb = 2'b00;
      ResultW = 19'($urandom);
      run_op("rand", ($urandom % 8) != 0, op, 19'($urandom), 19'($urandom), 19'($urandom),
             1'($urandom), fa, fb, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 5'($urandom));
    end

`ifdef EXECUTE_DIV_EN
    do_div("div", 4'b1001, 19'h00064, 19'h00007, 19'h0000E);
    do_div("rem", 4'b1010, 19'h00064, 19'h00007, 19'h00002);
    do_div("div0", 4'b1001, 19'h00123, 19'h0, 19'h7FFFF);
    do_div("rem0", 4'b1010, 19'h00123, 19'h0, 19'h00123);
    begin
      logic [18:0] a, b;
      a = 19'($urandom);
      b = 19'($urandom_range(1, 2000));
      do_div("div rand", 4'b1001, a, b, ref_alu(4'd9, a, b));
      do_div("rem rand", 4'b1010, a, b, ref_alu(4'd10, a, b));
    end
    @(negedge clk);
    setin(1, 4'b1001, 19'h64, 19'h7, 19'h0, 0, 2'b00, 2'b00, 1, 1, 1, 1, 5'd4);
    repeat (11) @(posedge clk);
`else
    run_op("div off", 1, 4'b1001, 19'h00064, 19'h00007, 19'h0, 0, 2'b00, 2'b00, 1, 0, 0, 0, 5'd3);
    chk("div off const", 32'(ALUResultM), 0);
    run_op("rem off", 1, 4'b1010, 19'h00064, 19'h00007, 19'h0, 0, 2'b00, 2'b00, 1, 0, 0, 0, 5'd3);
    run_op("pre reset", 1, 4'b0000, 19'h00100, 19'h0, 19'h1, 1, 2'b00, 2'b00, 1, 1, 1, 1, 5'd4);
`endif
    @(negedge clk);
    ValidE = 0;
    reset = 1'b0;
    #1;
    chk("midreset alu", 32'(ALUResultM), 0);
    chk("midreset wdata", 32'(WriteDataM), 0);
    chk("midreset regwrite", 32'(RegWriteM), 0);
    chk("midreset memwrite", 32'(MemWriteM), 0);
    chk("midreset rdm", 32'(RDM), 0);
    chk("midreset stall", 32'(StallE), 0);
    m_alu = '0;
    known = 1;
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 25; i++) begin
      @(posedge clk); #1;
      chk("no stale regwrite", 32'(RegWriteM), 0);
      chk("no stale stall", 32'(StallE), 0);
    end
    run_op("post reset add", 1, 4'b0000, 19'h00021, 19'h0, 19'h00002, 1, 2'b00, 2'b00, 1, 0, 0, 0, 5'd6);
    chk("post reset const", 32'(ALUResultM), 32'h23);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
